// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the round-robin packet mux arbiter.
package pkt_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int          N_INPUTS = 3;
    localparam logic [2:0]  SEL_IN0  = 3'b000;
    localparam logic [2:0]  SEL_IN1  = 3'b001;
    localparam logic [2:0]  SEL_IN2  = 3'b010;
    localparam logic [2:0]  SEL_NONE = 3'b111;

    function automatic logic [2:0] sel_code(input logic [1:0] idx);
        return {1'b0, idx};
    endfunction

    // Pointer advances modulo 3, so 2 wraps to 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester found scanning ptr, ptr+1, ptr+2 (mod 3).
module rr_priority_pick
    import pkt_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] o0, o1, o2;

    always_comb begin
        case (ptr)
            2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
    end

    always_comb begin
        any     = |req;
        gnt_idx = 2'd0;
        if (req[o0])
            gnt_idx = o0;
        else if (req[o1])
            gnt_idx = o1;
        else if (req[o2])
            gnt_idx = o2;
    end

endmodule

// File: rtl/packet_mux_rr_arbiter.sv
// Round-robin arbiter sharing one 3:1 packet mux; grant is held for a whole packet,
// with a registered output stage in front of the consumer.
module packet_mux_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*DATA_WIDTH-1:0] in_data,
    input  logic [2:0]              in_last,
    input  logic [2:0]              in_vld,
    output logic [2:0]              in_rd,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    out_vld,
    input  logic                    out_rd,
    output logic [2:0]              sel
);

    state_t                  state, state_nxt;
    logic [1:0]              ptr;
    logic [1:0]              pick_idx;
    logic                    pick_any;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    mux_last;
    logic                    mux_vld;
    logic                    room;
    logic                    xfer;
    logic                    eop;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    last_p1;
    logic                    vld_p1;

    rr_priority_pick u_pick (
        .req     (in_vld),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        mux_vld  = 1'b0;
        case (sel)
            SEL_IN0: begin
                mux_data = in_data[0*DATA_WIDTH +: DATA_WIDTH];
                mux_last = in_last[0];
                mux_vld  = in_vld[0];
            end
            SEL_IN1: begin
                mux_data = in_data[1*DATA_WIDTH +: DATA_WIDTH];
                mux_last = in_last[1];
                mux_vld  = in_vld[1];
            end
            SEL_IN2: begin
                mux_data = in_data[2*DATA_WIDTH +: DATA_WIDTH];
                mux_last = in_last[2];
                mux_vld  = in_vld[2];
            end
            default: begin
                mux_data = '0;
                mux_last = 1'b0;
                mux_vld  = 1'b0;
            end
        endcase
    end

    assign room = !vld_p1 || out_rd;
    assign xfer = (state == GRANT) && mux_vld && room;
    assign eop  = xfer && mux_last;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = GRANT;
            GRANT:   if (eop)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready depends only on state, select and output-register room, never on in_vld.
    always_comb begin
        in_rd = 3'b000;
        if (state == GRANT && room) begin
            case (sel)
                SEL_IN0: in_rd = 3'b001;
                SEL_IN1: in_rd = 3'b010;
                SEL_IN2: in_rd = 3'b100;
                default: in_rd = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= SEL_NONE;
            ptr <= 2'd0;
        end else if (state == IDLE && pick_any) begin
            sel <= sel_code(pick_idx);
        end else if (eop) begin
            sel <= SEL_NONE;
            ptr <= next_ptr(sel[1:0]);
        end
    end

    // Output stage p1: loads whenever empty or being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (room) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= mux_data;
                last_p1 <= mux_last;
            end
        end
    end

    assign out_data = data_p1;
    assign out_last = last_p1;
    assign out_vld  = vld_p1;

endmodule

// File: tb/tb_packet_mux_rr_arbiter.sv
// Directed self-checking bench for packet_mux_rr_arbiter.
module tb_packet_mux_rr_arbiter;

    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_last;
    logic [2:0]      in_vld;
    logic [2:0]      in_rd;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_vld;
    logic            out_rd;
    logic [2:0]      sel;

    int checks = 0;
    int errors = 0;

    packet_mux_rr_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_vld   (in_vld),
        .in_rd    (in_rd),
        .out_data (out_data),
        .out_last (out_last),
        .out_vld  (out_vld),
        .out_rd   (out_rd),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic set_in(input int idx, input logic [7:0] d, input logic l);
        in_data[idx*DW +: DW] = d;
        in_last[idx] = l;
    endtask

    int order [4] = '{1, 2, 0, 1};

    initial begin
        rst     = 1'b1;
        in_data = '0;
        in_last = '0;
        in_vld  = '0;
        out_rd  = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_data = 24'($urandom);
            in_last = 3'($urandom);
            in_vld  = 3'($urandom);
            out_rd  = 1'($urandom);
            tick();
        end
        settle();
        chk("rst_sel", 32'(sel), 32'h7);
        chk("rst_in_rd", 32'(in_rd), 32'h0);
        chk("rst_out_vld", 32'(out_vld), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);

        rst = 1'b0; in_data = '0; in_last = '0; in_vld = '0; out_rd = 1'b1;
        tick();

        // 2: single 3-beat packet on in0
        in_vld = 3'b001; set_in(0, 8'h11, 1'b0);
        settle();
        chk("t2_idle_sel", 32'(sel), 32'h7);
        chk("t2_idle_in_rd", 32'(in_rd), 32'h0);
        tick(); settle();
        chk("t2_grant_sel", 32'(sel), 32'h0);
        chk("t2_grant_in_rd", 32'(in_rd), 32'h1);
        chk("t2_grant_out_vld", 32'(out_vld), 32'h0);
        tick(); set_in(0, 8'h22, 1'b0); settle();
        chk("t2_b0_data", 32'(out_data), 32'h11);
        chk("t2_b0_vld", 32'(out_vld), 32'h1);
        chk("t2_b0_last", 32'(out_last), 32'h0);
        tick(); set_in(0, 8'h33, 1'b1); settle();
        chk("t2_b1_data", 32'(out_data), 32'h22);
        tick(); in_vld = 3'b000; set_in(0, 8'h00, 1'b0); settle();
        chk("t2_b2_data", 32'(out_data), 32'h33);
        chk("t2_b2_last", 32'(out_last), 32'h1);
        chk("t2_end_sel", 32'(sel), 32'h7);
        chk("t2_end_in_rd", 32'(in_rd), 32'h0);
        tick(); settle();
        chk("t2_drain_vld", 32'(out_vld), 32'h0);

        // 3: fairness, all requesting 1-beat packets; ptr is 1 after test 2
        in_vld = 3'b111;
        set_in(0, 8'hA0, 1'b1); set_in(1, 8'hA1, 1'b1); set_in(2, 8'hA2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk($sformatf("t3_sel_%0d", k), 32'(sel), 32'(order[k]));
            chk($sformatf("t3_in_rd_%0d", k), 32'(in_rd), 32'(1 << order[k]));
            tick();
            if (k == 3) in_vld = 3'b000;
            settle();
            chk($sformatf("t3_data_%0d", k), 32'(out_data), 32'(8'hA0 + order[k]));
            chk($sformatf("t3_last_%0d", k), 32'(out_last), 32'h1);
            chk($sformatf("t3_idle_sel_%0d", k), 32'(sel), 32'h7);
        end
        in_last = '0;
        tick(); settle();
        chk("t3_drain_vld", 32'(out_vld), 32'h0);

        // 4: backpressure mid-packet on in0 (ptr=2, only in0 requests)
        in_vld = 3'b001; set_in(0, 8'hB0, 1'b0);
        tick(); settle();
        chk("t4_grant_sel", 32'(sel), 32'h0);
        tick(); set_in(0, 8'hB1, 1'b0); settle();
        chk("t4_b0_data", 32'(out_data), 32'hB0);
        tick(); set_in(0, 8'hB2, 1'b0); out_rd = 1'b0; settle();
        chk("t4_b1_data", 32'(out_data), 32'hB1);
        chk("t4_bp_in_rd", 32'(in_rd), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk($sformatf("t4_hold_data_%0d", i), 32'(out_data), 32'hB1);
            chk($sformatf("t4_hold_vld_%0d", i), 32'(out_vld), 32'h1);
            chk($sformatf("t4_hold_in_rd_%0d", i), 32'(in_rd), 32'h0);
            chk($sformatf("t4_hold_sel_%0d", i), 32'(sel), 32'h0);
        end
        out_rd = 1'b1; settle();
        chk("t4_resume_in_rd", 32'(in_rd), 32'h1);
        tick(); set_in(0, 8'hB3, 1'b1); settle();
        chk("t4_b2_data", 32'(out_data), 32'hB2);
        chk("t4_b2_last", 32'(out_last), 32'h0);
        tick(); in_vld = 3'b000; set_in(0, 8'h00, 1'b0); settle();
        chk("t4_b3_data", 32'(out_data), 32'hB3);
        chk("t4_b3_last", 32'(out_last), 32'h1);
        chk("t4_end_sel", 32'(sel), 32'h7);
        tick();

        // 5: reset after 2 of 4 beats from in1 (ptr=1)
        in_vld = 3'b010; set_in(1, 8'hC0, 1'b0);
        tick(); settle();
        chk("t5_grant_sel", 32'(sel), 32'h1);
        tick(); set_in(1, 8'hC1, 1'b0); settle();
        chk("t5_b0_data", 32'(out_data), 32'hC0);
        tick(); set_in(1, 8'hC2, 1'b0); rst = 1'b1; settle();
        chk("t5_b1_data", 32'(out_data), 32'hC1);
        tick(); rst = 1'b0; in_vld = 3'b000; set_in(1, 8'h00, 1'b0); settle();
        chk("t5_rst_vld", 32'(out_vld), 32'h0);
        chk("t5_rst_sel", 32'(sel), 32'h7);
        chk("t5_rst_in_rd", 32'(in_rd), 32'h0);
        in_vld = 3'b100; set_in(2, 8'hD2, 1'b1);
        tick(); settle();
        chk("t5_in2_sel", 32'(sel), 32'h2);
        chk("t5_in2_in_rd", 32'(in_rd), 32'h4);
        tick(); in_vld = 3'b000; set_in(2, 8'h00, 1'b0); settle();
        chk("t5_in2_data", 32'(out_data), 32'hD2);
        chk("t5_in2_last", 32'(out_last), 32'h1);
        chk("t5_in2_end_sel", 32'(sel), 32'h7);
        tick();

        // 6: in0 drops vld for 2 cycles while in1 waits (ptr=0)
        in_vld = 3'b001; set_in(0, 8'hE0, 1'b0); set_in(1, 8'hF1, 1'b1);
        tick(); in_vld = 3'b011; settle();
        chk("t6_grant_sel", 32'(sel), 32'h0);
        tick(); in_vld = 3'b010; settle();
        chk("t6_e0_data", 32'(out_data), 32'hE0);
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            chk($sformatf("t6_gap_sel_%0d", i), 32'(sel), 32'h0);
            chk($sformatf("t6_gap_in_rd_%0d", i), 32'(in_rd), 32'h1);
            chk($sformatf("t6_gap_vld_%0d", i), 32'(out_vld), 32'h0);
        end
        in_vld = 3'b011; set_in(0, 8'hE1, 1'b0);
        tick(); set_in(0, 8'hE2, 1'b1); settle();
        chk("t6_e1_data", 32'(out_data), 32'hE1);
        chk("t6_e1_sel", 32'(sel), 32'h0);
        tick(); in_vld = 3'b010; settle();
        chk("t6_e2_data", 32'(out_data), 32'hE2);
        chk("t6_e2_sel", 32'(sel), 32'h7);
        tick(); settle();
        chk("t6_in1_sel", 32'(sel), 32'h1);
        chk("t6_in1_in_rd", 32'(in_rd), 32'h2);
        tick(); in_vld = 3'b000; settle();
        chk("t6_f1_data", 32'(out_data), 32'hF1);
        chk("t6_f1_last", 32'(out_last), 32'h1);
        chk("t6_f1_vld", 32'(out_vld), 32'h1);
        tick(); settle();
        chk("t6_drain_vld", 32'(out_vld), 32'h0);
        chk("t6_final_sel", 32'(sel), 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
